// File: rtl/jtsbaskt_pcm_fetch.sv
// -----------------------------------------------------------------------------
// jtsbaskt_pcm_fetch
//
// Speech-ROM fetch adapter between the VLM5030 byte address bus and an SDRAM
// ROM slot with a 16-bit data path. A current-word buffer (B0) serves byte
// reads combinationally. A one-word sequential prefetch buffer (B1) lets
// linear speech playback move to the next word without a full SDRAM
// round trip.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   flush     synchronous; drops both buffers and any SDRAM request
//   pcm_cs    VLM memory enable, requests are served only when high
//   pcm_addr  VLM byte address
//   pcm_data  byte for pcm_addr (holds the last valid byte when not ok)
//   pcm_ok    pcm_data is valid for the current pcm_addr
//   rom_addr  SDRAM word address
//   rom_cs    SDRAM request
//   rom_data  SDRAM word, byte 0 in [7:0], byte 1 in [15:8]
//   rom_ok    SDRAM data valid
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module jtsbaskt_pcm_fetch #(
    parameter int AW       = 16,
    parameter int PREFETCH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          pcm_cs,
    input  logic [AW-1:0] pcm_addr,
    output logic [7:0]    pcm_data,
    output logic          pcm_ok,
    output logic [AW-2:0] rom_addr,
    output logic          rom_cs,
    input  logic [15:0]   rom_data,
    input  logic          rom_ok
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PROMOTE,
        PREF
    } state_t;

    state_t        state_q,   state_d;
    logic [AW-2:0] b0Tag_q,   b0Tag_d;
    logic [15:0]   b0Data_q,  b0Data_d;
    logic          b0Valid_q, b0Valid_d;
    logic [AW-2:0] b1Tag_q,   b1Tag_d;
    logic [15:0]   b1Data_q,  b1Data_d;
    logic          b1Valid_q, b1Valid_d;
    logic          romCs_q,   romCs_d;
    logic [AW-2:0] romAddr_q, romAddr_d;
    logic          armed_q,   armed_d;
    logic [7:0]    lastData_q, lastData_d;

    logic [AW-2:0] waddr;
    logic          b0Hit;
    logic          b1Hit;
    logic          accept;
    logic [7:0]    hitByte;

    assign waddr   = pcm_addr[AW-1:1];
    assign b0Hit   = b0Valid_q && (b0Tag_q == waddr);
    assign b1Hit   = b1Valid_q && (b1Tag_q == waddr);
    assign hitByte = pcm_addr[0] ? b0Data_q[15:8] : b0Data_q[7:0];

    // armed_q means rom_cs was already high with this same rom_addr on the
    // previous cycle, so rom_ok now belongs to our request and not to a
    // leftover from an earlier one.
    assign accept = romCs_q && armed_q && rom_ok;

    assign pcm_ok   = pcm_cs && b0Hit && !flush;
    assign pcm_data = pcm_ok ? hitByte : lastData_q;
    assign rom_cs   = romCs_q;
    assign rom_addr = romAddr_q;

    // Next-state logic for the buffers, SDRAM request and fetch FSM.
    // flush is applied last so it overrides every state action.
    always_comb begin
        state_d    = state_q;
        b0Tag_d    = b0Tag_q;
        b0Data_d   = b0Data_q;
        b0Valid_d  = b0Valid_q;
        b1Tag_d    = b1Tag_q;
        b1Data_d   = b1Data_q;
        b1Valid_d  = b1Valid_q;
        romCs_d    = romCs_q;
        romAddr_d  = romAddr_q;
        lastData_d = pcm_ok ? hitByte : lastData_q;

        case (state_q)
            IDLE: begin
                romCs_d = 1'b0;
                if (pcm_cs && !b0Hit) begin
                    if (b1Hit) begin
                        state_d = PROMOTE;
                    end else begin
                        state_d   = FILL;
                        romCs_d   = 1'b1;
                        romAddr_d = waddr;
                    end
                end
            end

            PROMOTE: begin
                b0Tag_d   = b1Tag_q;
                b0Data_d  = b1Data_q;
                b0Valid_d = b1Valid_q;
                b1Valid_d = 1'b0;
                state_d   = (PREFETCH != 0) ? PREF : IDLE;
            end

            FILL: begin
                // A new address from the VLM restarts the fill; the word in
                // flight for the old address is never written to B0.
                romCs_d = 1'b1;
                if (pcm_cs && (waddr != romAddr_q)) begin
                    romAddr_d = waddr;
                end else if (accept) begin
                    b0Tag_d   = romAddr_q;
                    b0Data_d  = rom_data;
                    b0Valid_d = 1'b1;
                    romCs_d   = 1'b0;
                    state_d   = (PREFETCH != 0) ? PREF : IDLE;
                end
            end

            PREF: begin
                // A demand miss wins over the prefetch. rom_cs drops for a
                // cycle so the new address appears while rom_cs is low.
                if (pcm_cs && !b0Hit) begin
                    b1Valid_d = 1'b0;
                    romCs_d   = 1'b0;
                    romAddr_d = waddr;
                    state_d   = FILL;
                end else if (accept) begin
                    b1Tag_d   = romAddr_q;
                    b1Data_d  = rom_data;
                    b1Valid_d = 1'b1;
                    romCs_d   = 1'b0;
                    state_d   = IDLE;
                end else if (!romCs_q) begin
                    romCs_d   = 1'b1;
                    romAddr_d = b0Tag_q + {{(AW-2){1'b0}}, 1'b1};
                end
            end

            default: begin
                state_d = IDLE;
                romCs_d = 1'b0;
            end
        endcase

        if (flush) begin
            b0Valid_d = 1'b0;
            b1Valid_d = 1'b0;
            romCs_d   = 1'b0;
            romAddr_d = romAddr_q;
            state_d   = IDLE;
        end

        armed_d = romCs_d && romCs_q && (romAddr_d == romAddr_q);
    end

    // State registers. Reset clears the request at once so the SDRAM slot
    // sees rom_cs fall even in the middle of a fill or prefetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            b0Tag_q    <= '0;
            b0Data_q   <= '0;
            b0Valid_q  <= 1'b0;
            b1Tag_q    <= '0;
            b1Data_q   <= '0;
            b1Valid_q  <= 1'b0;
            romCs_q    <= 1'b0;
            romAddr_q  <= '0;
            armed_q    <= 1'b0;
            lastData_q <= '0;
        end else begin
            state_q    <= state_d;
            b0Tag_q    <= b0Tag_d;
            b0Data_q   <= b0Data_d;
            b0Valid_q  <= b0Valid_d;
            b1Tag_q    <= b1Tag_d;
            b1Data_q   <= b1Data_d;
            b1Valid_q  <= b1Valid_d;
            romCs_q    <= romCs_d;
            romAddr_q  <= romAddr_d;
            armed_q    <= armed_d;
            lastData_q <= lastData_d;
        end
    end

endmodule

// File: tb/tb_jtsbaskt_pcm_fetch.sv
// -----------------------------------------------------------------------------
// tb_jtsbaskt_pcm_fetch
//
// Directed scenarios followed by randomized VLM traffic. The ROM contents live
// in an array; an SDRAM responder returns garbage until a request has been
// stable for its latency. A monitor checks every pcm_ok byte against the ROM
// and that pcm_data holds the last good byte otherwise.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_jtsbaskt_pcm_fetch;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          pcm_cs = 1'b0;
    logic [AW-1:0] pcm_addr = '0;
    logic [7:0]    pcm_data;
    logic          pcm_ok;
    logic [AW-2:0] rom_addr;
    logic          rom_cs;
    logic [15:0]   rom_data;
    logic          rom_ok;

    logic [15:0]   mem [0:32767];

    int vectors = 0;
    int miscompares = 0;
    int latency = 1;
    bit okStuck = 1'b0;

    jtsbaskt_pcm_fetch #(.AW(AW), .PREFETCH(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .pcm_cs   (pcm_cs),
        .pcm_addr (pcm_addr),
        .pcm_data (pcm_data),
        .pcm_ok   (pcm_ok),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_data (rom_data),
        .rom_ok   (rom_ok)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cs, input logic [AW-1:0] addr,
                                 input logic fl);
        pcm_cs   = cs;
        pcm_addr = addr;
        flush    = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flushIdle();
        step();
        applyStimulus(1'b0, pcm_addr, 1'b1);
        step();
        applyStimulus(1'b0, pcm_addr, 1'b0);
    endtask

    task automatic waitPcmOk(input string tag);
        bit got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (pcm_ok) got = 1'b1;
            else step();
        end
        checkOutput(tag, 32'(got), 32'd1);
    endtask

    task automatic waitRomIdle(input string tag);
        bit got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (!rom_cs) got = 1'b1;
            else step();
        end
        checkOutput(tag, 32'(got), 32'd1);
    endtask

    // SDRAM responder: rom_ok once the request has been stable for
    // `latency` cycles after the first one; in stuck mode rom_ok is always
    // high but data is junk on the first cycle of every request.
    initial begin
        int sameCnt = 0;
        bit prevCs = 1'b0;
        logic [AW-2:0] prevAddr = '0;
        bit ready;
        rom_ok   = 1'b0;
        rom_data = '0;
        forever begin
            @(negedge clk);
            if (rom_cs && prevCs && rom_addr == prevAddr) sameCnt++;
            else sameCnt = 0;
            prevCs   = rom_cs;
            prevAddr = rom_addr;
            ready = rom_cs && (sameCnt >= latency);
            if (okStuck) begin
                rom_ok   = 1'b1;
                rom_data = (rom_cs && sameCnt >= 1) ? mem[rom_addr] : 16'($urandom);
            end else begin
                rom_ok   = ready;
                rom_data = ready ? mem[rom_addr] : 16'($urandom);
            end
        end
    end

    // Output monitor: data correctness, data hold, and rom_addr only moving
    // under an active request when the VLM asked for a different word.
    initial begin
        logic [7:0]    lastByte = '0;
        logic [7:0]    expByte;
        logic [15:0]   word;
        bit            prevRomCs = 1'b0;
        logic [AW-2:0] prevRomAddr = '0;
        bit            prevPcmCs = 1'b0;
        logic [AW-2:0] prevWaddr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lastByte  = '0;
                prevRomCs = 1'b0;
            end else begin
                if (pcm_ok) begin
                    word    = mem[pcm_addr[AW-1:1]];
                    expByte = pcm_addr[0] ? word[15:8] : word[7:0];
                    checkOutput("hitData", 32'(pcm_data), 32'(expByte));
                    checkOutput("okQualified", 32'({pcm_cs, flush}), 32'd2);
                    lastByte = expByte;
                end else begin
                    checkOutput("holdData", 32'(pcm_data), 32'(lastByte));
                end
                if (rom_cs && prevRomCs && rom_addr != prevRomAddr)
                    checkOutput("restartAddr", 32'({prevPcmCs, rom_addr}),
                                32'({1'b1, prevWaddr}));
                prevRomCs   = rom_cs;
                prevRomAddr = rom_addr;
                prevPcmCs   = pcm_cs;
                prevWaddr   = pcm_addr[AW-1:1];
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired, vectors=%0d", vectors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [AW-1:0] addr;
        int r;

        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[8] = 16'hBEEF;
        mem[9] = 16'h1234;

        // Reset values
        applyStimulus(1'b0, '0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetPcmOk", 32'(pcm_ok), 32'd0);
        checkOutput("resetPcmData", 32'(pcm_data), 32'd0);
        checkOutput("resetRomCs", 32'(rom_cs), 32'd0);
        checkOutput("resetRomAddr", 32'(rom_addr), 32'd0);
        rst_n = 1'b1;
        step();

        // Cold miss at minimum latency
        latency = 1;
        applyStimulus(1'b1, 16'h0010, 1'b0);
        @(negedge clk);
        checkOutput("coldOk0", 32'(pcm_ok), 32'd0);
        step(); @(negedge clk);
        checkOutput("coldRomCs1", 32'(rom_cs), 32'd1);
        checkOutput("coldRomAddr1", 32'(rom_addr), 32'h0008);
        checkOutput("coldOk1", 32'(pcm_ok), 32'd0);
        step(); @(negedge clk);
        checkOutput("coldOk2", 32'(pcm_ok), 32'd0);
        step(); @(negedge clk);
        checkOutput("coldOk3", 32'(pcm_ok), 32'd1);
        checkOutput("coldData3", 32'(pcm_data), 32'h00EF);
        step();
        applyStimulus(1'b1, 16'h0011, 1'b0);
        @(negedge clk);
        checkOutput("oddByteOk", 32'(pcm_ok), 32'd1);
        checkOutput("oddByteData", 32'(pcm_data), 32'h00BE);
        checkOutput("prefRomCs", 32'(rom_cs), 32'd1);
        checkOutput("prefRomAddr", 32'(rom_addr), 32'h0009);
        step(); step(); @(negedge clk);
        checkOutput("prefDone", 32'(rom_cs), 32'd0);

        // Promote of the prefetched word
        step();
        applyStimulus(1'b1, 16'h0012, 1'b0);
        @(negedge clk);
        checkOutput("promOk0", 32'(pcm_ok), 32'd0);
        step(); @(negedge clk);
        checkOutput("promOk1", 32'(pcm_ok), 32'd0);
        checkOutput("promNoFetch", 32'(rom_cs), 32'd0);
        step(); @(negedge clk);
        checkOutput("promOk2", 32'(pcm_ok), 32'd1);
        checkOutput("promData", 32'(pcm_data), 32'h0034);
        step(); @(negedge clk);
        checkOutput("promPrefCs", 32'(rom_cs), 32'd1);
        checkOutput("promPrefAddr", 32'(rom_addr), 32'h000A);
        waitRomIdle("promPrefIdle");

        // Address change in the middle of a fill
        flushIdle();
        latency = 2;
        applyStimulus(1'b1, 16'h0100, 1'b0);
        step();
        applyStimulus(1'b1, 16'h0200, 1'b0);
        @(negedge clk);
        checkOutput("chgRomAddrA", 32'(rom_addr), 32'h0080);
        step(); @(negedge clk);
        checkOutput("chgRomAddrB", 32'(rom_addr), 32'h0100);
        checkOutput("chgRomCs", 32'(rom_cs), 32'd1);
        checkOutput("chgOk", 32'(pcm_ok), 32'd0);
        waitPcmOk("chgServed");
        step();
        applyStimulus(1'b1, 16'h0100, 1'b0);
        @(negedge clk);
        checkOutput("chgStaleMiss", 32'(pcm_ok), 32'd0);

        // rom_ok stuck high
        flushIdle();
        okStuck = 1'b1;
        latency = 1;
        applyStimulus(1'b1, 16'h0300, 1'b0);
        step(); @(negedge clk);
        checkOutput("stuckOk1", 32'(pcm_ok), 32'd0);
        step(); @(negedge clk);
        checkOutput("stuckOk2", 32'(pcm_ok), 32'd0);
        step(); @(negedge clk);
        checkOutput("stuckOk3", 32'(pcm_ok), 32'd1);
        checkOutput("stuckData", 32'(pcm_data), 32'(mem[15'h0180][7:0]));
        step(); step();
        waitRomIdle("stuckPrefIdle");
        step();
        applyStimulus(1'b1, 16'h0302, 1'b0);
        waitPcmOk("stuckPromServed");
        okStuck = 1'b0;

        // Wrap of the prefetch address
        flushIdle();
        latency = 1;
        applyStimulus(1'b1, 16'hFFFE, 1'b0);
        step(); step(); step(); @(negedge clk);
        checkOutput("wrapOk", 32'(pcm_ok), 32'd1);
        step(); @(negedge clk);
        checkOutput("wrapPrefAddr", 32'(rom_addr), 32'h0000);
        checkOutput("wrapPrefCs", 32'(rom_cs), 32'd1);
        waitRomIdle("wrapPrefIdle");
        step();
        applyStimulus(1'b1, 16'h0000, 1'b0);
        step(); @(negedge clk);
        checkOutput("wrapPromNoFetch", 32'(rom_cs), 32'd0);
        step(); @(negedge clk);
        checkOutput("wrapPromOk", 32'(pcm_ok), 32'd1);
        checkOutput("wrapPromData", 32'(pcm_data), 32'(mem[0][7:0]));

        // Flush during prefetch with coincident rom_ok
        flushIdle();
        latency = 1;
        applyStimulus(1'b1, 16'h0400, 1'b0);
        step(); step(); step(); @(negedge clk);
        checkOutput("flOk3", 32'(pcm_ok), 32'd1);
        step(); @(negedge clk);
        checkOutput("flPrefCs", 32'(rom_cs), 32'd1);
        step();
        applyStimulus(1'b1, 16'h0400, 1'b1);
        @(negedge clk);
        checkOutput("flMasked", 32'(pcm_ok), 32'd0);
        step();
        applyStimulus(1'b1, 16'h0402, 1'b0);
        @(negedge clk);
        checkOutput("flRomCs", 32'(rom_cs), 32'd0);
        checkOutput("flB1Miss", 32'(pcm_ok), 32'd0);
        step(); @(negedge clk);
        checkOutput("flRefill", 32'(rom_cs), 32'd1);
        checkOutput("flRefillAddr", 32'(rom_addr), 32'h0201);
        waitPcmOk("flRefillServed");
        step();
        applyStimulus(1'b1, 16'h0400, 1'b0);
        @(negedge clk);
        checkOutput("flRereadMiss", 32'(pcm_ok), 32'd0);

        // Asynchronous reset in the middle of a fill
        flushIdle();
        latency = 4;
        applyStimulus(1'b1, 16'h0500, 1'b0);
        step(); @(negedge clk);
        checkOutput("rstPreCs", 32'(rom_cs), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstPcmOk", 32'(pcm_ok), 32'd0);
        checkOutput("rstRomCs", 32'(rom_cs), 32'd0);
        checkOutput("rstPcmData", 32'(pcm_data), 32'd0);
        checkOutput("rstRomAddr", 32'(rom_addr), 32'd0);
        applyStimulus(1'b0, 16'h0500, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized VLM traffic
        addr = 16'h0040;
        for (int n = 0; n < 300; n++) begin
            r       = int'($urandom_range(0, 99));
            latency = int'($urandom_range(1, 4));
            okStuck = ($urandom_range(0, 9) == 0);
            if (r < 5) begin
                flushIdle();
            end else if (r < 15) begin
                step();
                applyStimulus(1'b0, 16'($urandom), 1'b0);
                repeat ($urandom_range(1, 3)) step();
            end else begin
                if (r < 70)      addr = addr + 16'd1;
                else if (r < 80) addr = addr + 16'd2;
                else if (r < 90) addr = 16'hFFF0 + 16'($urandom_range(0, 15));
                else             addr = 16'($urandom);
                step();
                applyStimulus(1'b1, addr, 1'b0);
                if (r % 8 == 0) begin
                    step();
                    addr = 16'($urandom);
                    applyStimulus(1'b1, addr, 1'b0);
                end
                waitPcmOk("randServed");
            end
        end
        okStuck = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
